// File: rtl/cic_corr_round_sat.sv
// CIC correction post-multiplier: delays valid/tlast to meet the product, rounds and saturates it, then buffers it in a FWFT FIFO.
// Latency is MULT_LAT+2 cycles from accept to m_axis_tvalid; s_axis_tready is a credit covering FIFO plus in-flight samples.

module cic_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         sync_reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop & ~empty;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module cic_corr_round_sat #(
  parameter int MULT_LAT   = 4,
  parameter int SHIFT      = 12,
  parameter int OUT_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  input  logic [47:0]      p,
  output logic [OUT_W-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             sat_flag,
  input  logic             sat_clr
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic signed [48:0] RND  = 49'sd1 <<< (SHIFT-1);
  localparam logic signed [48:0] MAXV = (49'sd1 <<< (OUT_W-1)) - 49'sd1;
  localparam logic signed [48:0] MINV = -(49'sd1 <<< (OUT_W-1));

  logic [MULT_LAT-1:0] vld_sr, last_sr;
  logic                accept, dl_vld;
  logic signed [48:0]  sum, r;
  logic                sat_hi, sat_lo;
  logic [OUT_W-1:0]    sample;
  logic                rnd_vld, rnd_last;
  logic [OUT_W-1:0]    rnd_dat;
  logic [OUT_W:0]      fifo_head;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;
  logic [15:0]         credit_used;

  assign accept = s_axis_tvalid & s_axis_tready;
  assign dl_vld = vld_sr[MULT_LAT-1];

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      vld_sr  <= '0;
      last_sr <= '0;
    end else begin
      vld_sr[0]  <= accept;
      last_sr[0] <= accept & s_axis_tlast;
      for (int i = 1; i < MULT_LAT; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
    end
  end

  // One guard bit above the 48-bit product keeps the rounding add from overflowing.
  always_comb begin
    sum    = $signed({p[47], p}) + RND;
    r      = sum >>> SHIFT;
    sat_hi = (r > MAXV);
    sat_lo = (r < MINV);
    if (sat_hi)      sample = MAXV[OUT_W-1:0];
    else if (sat_lo) sample = MINV[OUT_W-1:0];
    else             sample = r[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      rnd_vld  <= 1'b0;
      rnd_last <= 1'b0;
      rnd_dat  <= '0;
    end else begin
      rnd_vld  <= dl_vld;
      rnd_last <= last_sr[MULT_LAT-1];
      rnd_dat  <= sample;
    end
  end

  // A same-cycle saturation outranks the clear.
  always_ff @(posedge clk) begin
    if (sync_reset)                      sat_flag <= 1'b0;
    else if (dl_vld & (sat_hi | sat_lo)) sat_flag <= 1'b1;
    else if (sat_clr)                    sat_flag <= 1'b0;
  end

  cic_fifo #(.W(OUT_W+1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .sync_reset (sync_reset),
    .push       (rnd_vld),
    .push_dat   ({rnd_last, rnd_dat}),
    .pop        (m_axis_tvalid & m_axis_tready),
    .head       (fifo_head),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_head[OUT_W-1:0];
  assign m_axis_tlast  = ~fifo_empty & fifo_head[OUT_W];

  always_comb begin
    credit_used = 16'(fifo_count) + 16'(rnd_vld);
    for (int i = 0; i < MULT_LAT; i++) credit_used = credit_used + 16'(vld_sr[i]);
  end

  assign s_axis_tready = (credit_used < 16'(FIFO_DEPTH));
endmodule

// File: doc/cic_corr_round_sat.md
CIC_CORR_ROUND_SAT -- requirements
Module: cic_corr_round_sat

Interface
REQ-001 SHALL have parameter MULT_LAT, default 4, meaning the cycle latency from correction-multiplier operand input to its 48-bit product output.
REQ-002 SHALL have parameter SHIFT, default 12, meaning the right-shift applied to the product, with legal range 1..40.
REQ-003 SHALL have parameter OUT_W, default 16, meaning the signed output sample width, with legal range 2..32.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, meaning the output buffer depth, a power of 2 and at least MULT_LAT+2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port sync_reset, input, 1 bit: the reset, synchronous and active-high.
REQ-007 SHALL have port s_axis_tvalid, input, 1 bit: operands presented to the multiplier this cycle.
REQ-008 SHALL have port s_axis_tready, output, 1 bit: operand-acceptance credit.
REQ-009 SHALL have port s_axis_tlast, input, 1 bit: end-of-frame marker for the operand.
REQ-010 SHALL have port p, input, 48 bits: signed multiplier product.
REQ-011 SHALL have port m_axis_tdata, output, OUT_W bits: rounded, saturated sample.
REQ-012 SHALL have ports m_axis_tvalid (output, 1 bit), m_axis_tready (input, 1 bit) and m_axis_tlast (output, 1 bit), forming the AXI-Stream output.
REQ-013 SHALL have port sat_flag, output, 1 bit: sticky flag that goes high once any sample has saturated.
REQ-014 SHALL have port sat_clr, input, 1 bit: clears sat_flag.

Function
REQ-015 SHALL define acceptance as s_axis_tvalid & s_axis_tready in cycle t; the matching product then appears on p in cycle t+MULT_LAT.
REQ-016 SHALL carry valid and tlast through a MULT_LAT-stage shift register, so the delayed valid and tlast align with p.
REQ-017 SHALL drop s_axis_tvalid when s_axis_tready is low: nothing enters the delay line and the upstream multiplier output is ignored.
REQ-018 SHALL round the product as r = (p + 2^(SHIFT-1)) >>> SHIFT, using an arithmetic shift at 48-bit-plus-1 width with no intermediate overflow.
REQ-019 SHALL saturate r to the range [-2^(OUT_W-1), 2^(OUT_W-1)-1]; a saturating sample sets sat_flag.
REQ-020 SHALL register the rounded and saturated sample, together with tlast, in one stage (cycle t+MULT_LAT+1) and write it to the FIFO at the end of that cycle.
REQ-021 SHALL give a minimum latency from acceptance to m_axis_tvalid of MULT_LAT+2 cycles when the FIFO is empty (6 at default).
REQ-022 SHALL implement the FIFO as first-word-fall-through: m_axis_tvalid = FIFO not empty, and m_axis_tdata/m_axis_tlast show the head entry and hold stable while tvalid is high and tready is low.
REQ-023 SHALL pop on m_axis_tvalid & m_axis_tready; a simultaneous push and pop leaves the count unchanged, including when the FIFO is full.
REQ-024 SHALL use wrapping read/write pointers of log2(FIFO_DEPTH) bits, with the count held separately in the range 0..FIFO_DEPTH.
REQ-025 SHALL compute s_axis_tready = (fifo_count + inflight) < FIFO_DEPTH, where inflight is the number of valid entries in the delay line plus the round stage; this credit guarantees the FIFO never overflows.
REQ-026 SHALL drive s_axis_tready combinationally from registered state only, with no path from m_axis_tready.
REQ-027 SHALL give sat_clr priority lower than a same-cycle saturation: if both occur, sat_flag stays 1.

Reset
REQ-028 SHALL, on a sync_reset cycle, clear the delay line, the round-stage valid, the FIFO pointers and count, and sat_flag.
REQ-029 SHALL, after reset, output m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0 and s_axis_tready=1 (from the first cycle after reset).
REQ-030 SHALL discard all in-flight samples on a reset asserted mid-stream; products arriving on p after reset are ignored.

Verification
REQ-031 SHALL pass this scenario: single accept with p=0x000000000800 at cycle t+4 and SHIFT=12 -> m_axis_tdata=1 with tvalid first high at t+6.
REQ-032 SHALL pass this rounding scenario: p=-2048 -> output 0; p=-2049 -> output -1; p=2047 -> output 0.
REQ-033 SHALL pass this saturation scenario: p=0x0000_1000_0000 -> output 0x7FFF and sat_flag=1; a following sat_clr pulse with no saturation -> sat_flag=0; p=-2^40 -> output 0x8000.
REQ-034 SHALL pass this backpressure scenario: m_axis_tready=0 with continuous tvalid -> exactly 8 accepts and then s_axis_tready=0; after releasing tready, all 8 samples come out in order with tlast on the 4th if it was set on the 4th input.
REQ-035 SHALL pass this full-throughput scenario: 100 back-to-back samples with m_axis_tready=1 -> s_axis_tready stays 1 and output tvalid is continuous after the 6-cycle fill.
REQ-036 SHALL pass this reset scenario: sync_reset pulsed with 3 samples in flight and 2 in the FIFO -> no output until new accepts, and the next output corresponds to the first post-reset input.
